// File: rtl/outmf_rd_streamer.sv
// rtl/outmf_rd_streamer.sv - read-side burst engine turning outmf_dram port B reads into a ready/valid stream
module outmf_rd_streamer #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   start_len,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
);
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_W:0]   CNT_ONE  = 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W:0]     len_q, issued_q, popped_q;
    logic                inflight_q;
    logic [1:0]          fifo_cnt_q, fifo_cnt_d;
    logic [DATA_W-1:0]   f0_q, f1_q, f0_d, f1_d;
    logic                done_q, done_d;
    logic                issue, pop, pop_fifo, push;
    logic [2:0]          occ;
    logic [DATA_W-1:0]   head;

    // Occupancy counts FIFO entries plus the read still coming back from the RAM.
    always_comb begin
        occ      = {1'b0, fifo_cnt_q} + {2'b00, inflight_q};
        m_valid  = (occ != 3'd0);
        // An empty FIFO with a read in flight presents the RAM output directly.
        head     = (fifo_cnt_q != 2'd0) ? f0_q : rd_data;
        m_data   = m_valid ? head : '0;
        m_last   = m_valid && (popped_q == (len_q - CNT_ONE));
        pop      = m_valid && m_ready;
        pop_fifo = pop && (fifo_cnt_q != 2'd0);
        push     = inflight_q && !(pop && (fifo_cnt_q == 2'd0));
        issue    = (state_q == RUN) && (issued_q < len_q) &&
                   (occ < (3'd2 + {2'b00, pop}));
        rd_en    = issue;
        rd_addr  = addr_q;
        busy     = (state_q == RUN);
        done     = done_q;
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN: begin
                if ((len_q == '0) || (pop && m_last)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        f0_d       = f0_q;
        f1_d       = f1_q;
        fifo_cnt_d = fifo_cnt_q;
        if (pop_fifo) begin
            f0_d       = f1_q;
            fifo_cnt_d = fifo_cnt_d - 2'd1;
        end
        if (push) begin
            if (fifo_cnt_d == 2'd0) f0_d = rd_data;
            else                    f1_d = rd_data;
            fifo_cnt_d = fifo_cnt_d + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            done_q     <= 1'b0;
            addr_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            popped_q   <= '0;
            inflight_q <= 1'b0;
            fifo_cnt_q <= 2'd0;
            f0_q       <= '0;
            f1_q       <= '0;
        end else begin
            assert (!(push && !pop_fifo && (fifo_cnt_q == 2'd2)));
            state_q    <= state_d;
            done_q     <= done_d;
            inflight_q <= issue;
            fifo_cnt_q <= fifo_cnt_d;
            f0_q       <= f0_d;
            f1_q       <= f1_d;
            if ((state_q == IDLE) && start) begin
                addr_q   <= start_addr;
                len_q    <= start_len;
                issued_q <= '0;
                popped_q <= '0;
            end else begin
                if (issue) begin
                    addr_q   <= addr_q + ADDR_ONE;
                    issued_q <= issued_q + CNT_ONE;
                end
                if (pop) popped_q <= popped_q + CNT_ONE;
            end
        end
    end
endmodule

// File: tb/tb_outmf_rd_streamer.sv
// tb/tb_outmf_rd_streamer.sv - directed bench for outmf_rd_streamer with a 1-cycle RAM model
module tb_outmf_rd_streamer;
    logic        clk = 1'b0;
    logic        rst, start, busy, done, rd_en, m_valid, m_ready, m_last;
    logic [4:0]  start_addr, rd_addr;
    logic [5:0]  start_len;
    logic [31:0] rd_data, m_data;
    logic [31:0] mem [32];

    int tests = 0, fails = 0;
    int rd_cnt = 0, held = 0, viol = 0, stab_err = 0, done_cnt = 0;
    bit prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic [31:0] beat_q[$];
    bit          last_q[$];
    logic [4:0]  addr_log[$];
    bit ok;

    outmf_rd_streamer #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
        .start_len(start_len), .busy(busy), .done(done), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_data(rd_data), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'hA500_0000 + i;
        rd_data = '0;
    end

    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    // Stream / read-port monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            beat_q.push_back(m_data);
            last_q.push_back(m_last);
        end
        if (rd_en) begin
            addr_log.push_back(rd_addr);
            rd_cnt++;
            if (held - int'(m_valid && m_ready) >= 2) viol++;
        end
        if (rst) held = 0;
        else     held = held + int'(rd_en) - int'(m_valid && m_ready);
        if (prev_stall && m_data !== prev_data) stab_err++;
        prev_stall = m_valid && !m_ready && !rst;
        prev_data  = m_data;
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        beat_q.delete();
        last_q.delete();
        addr_log.delete();
        rd_cnt = 0;
    endtask

    task automatic kick(input logic [4:0] a, input logic [5:0] l);
        start = 1'b1; start_addr = a; start_len = l;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int maxc, input bit rnd, output bit found);
        found = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            if (done) begin found = 1'b1; break; end
            tick();
            if (rnd) m_ready = 1'($urandom_range(0, 1));
        end
        if (done) found = 1'b1;
        m_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start_addr = '0; start_len = '0; m_ready = 1'b1;
        repeat (3) tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_rd_en", 32'(rd_en), 0);
        check("rst_rd_addr", 32'(rd_addr), 0);
        check("rst_m_valid", 32'(m_valid), 0);
        check("rst_m_last", 32'(m_last), 0);
        check("rst_m_data", m_data, 0);
        rst = 1'b0;
        tick();

        // 1: addr 0, len 4, full-rate timing
        clear_logs();
        kick(5'd0, 6'd4);
        check("t1_busy_T1", 32'(busy), 1);
        check("t1_rd_en_T1", 32'(rd_en), 1);
        check("t1_rd_addr_T1", 32'(rd_addr), 0);
        check("t1_m_valid_T1", 32'(m_valid), 0);
        tick();
        check("t1_m_valid_T2", 32'(m_valid), 1);
        check("t1_m_data_T2", m_data, 32'hA500_0000);
        check("t1_m_last_T2", 32'(m_last), 0);
        tick(); tick(); tick();
        check("t1_m_data_T5", m_data, 32'hA500_0003);
        check("t1_m_last_T5", 32'(m_last), 1);
        tick();
        check("t1_done_T6", 32'(done), 1);
        check("t1_busy_T6", 32'(busy), 0);
        check("t1_beats", 32'(beat_q.size()), 4);
        for (int i = 0; i < 4; i++) check("t1_data", beat_q[i], 32'hA500_0000 + i);
        tick();
        check("t1_done_pulse", 32'(done), 0);

        // 2: address wrap
        clear_logs();
        kick(5'd30, 6'd4);
        wait_done(20, 1'b0, ok);
        check("t2_done_seen", 32'(ok), 1);
        check("t2_reads", 32'(addr_log.size()), 4);
        check("t2_addr0", 32'(addr_log[0]), 30);
        check("t2_addr1", 32'(addr_log[1]), 31);
        check("t2_addr2", 32'(addr_log[2]), 0);
        check("t2_addr3", 32'(addr_log[3]), 1);
        check("t2_data0", beat_q[0], 32'hA500_001E);
        check("t2_data1", beat_q[1], 32'hA500_001F);
        check("t2_data2", beat_q[2], 32'hA500_0000);
        check("t2_data3", beat_q[3], 32'hA500_0001);
        tick();

        // 3: full window under random backpressure
        clear_logs();
        viol = 0; stab_err = 0;
        kick(5'd0, 6'd32);
        wait_done(400, 1'b1, ok);
        check("t3_done_seen", 32'(ok), 1);
        check("t3_beats", 32'(beat_q.size()), 32);
        check("t3_reads", 32'(rd_cnt), 32);
        for (int i = 0; i < 32; i++) begin
            check("t3_data", beat_q[i], 32'hA500_0000 + i);
            check("t3_last", 32'(last_q[i]), (i == 31) ? 1 : 0);
        end
        check("t3_issue_viol", 32'(viol), 0);
        check("t3_stable", 32'(stab_err), 0);
        tick();

        // 4: zero-length burst
        clear_logs();
        kick(5'd7, 6'd0);
        check("t4_busy", 32'(busy), 1);
        check("t4_rd_en", 32'(rd_en), 0);
        tick();
        check("t4_done", 32'(done), 1);
        check("t4_busy_low", 32'(busy), 0);
        check("t4_reads", 32'(rd_cnt), 0);
        check("t4_beats", 32'(beat_q.size()), 0);
        tick();

        // 5: ignored restart, then reset at beat 3 of len 8
        clear_logs();
        done_cnt = 0;
        kick(5'd0, 6'd8);
        start = 1'b1; start_addr = 5'd20; start_len = 6'd3;
        tick();
        start = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_rst_busy", 32'(busy), 0);
        check("t5_rst_done", 32'(done), 0);
        check("t5_rst_rd_en", 32'(rd_en), 0);
        check("t5_rst_rd_addr", 32'(rd_addr), 0);
        check("t5_rst_m_valid", 32'(m_valid), 0);
        check("t5_rst_m_last", 32'(m_last), 0);
        check("t5_rst_m_data", m_data, 0);
        check("t5_beats", 32'(beat_q.size()), 3);
        check("t5_beat2", beat_q[2], 32'hA500_0002);
        tick();
        check("t5_no_done", 32'(done_cnt), 0);
        clear_logs();
        kick(5'd10, 6'd3);
        wait_done(20, 1'b0, ok);
        check("t5_fresh_done", 32'(ok), 1);
        check("t5_fresh_beats", 32'(beat_q.size()), 3);
        for (int i = 0; i < 3; i++) check("t5_fresh_data", beat_q[i], 32'hA500_000A + i);
        tick();

        // 6: back-to-back start on the done cycle
        clear_logs();
        kick(5'd0, 6'd2);
        wait_done(20, 1'b0, ok);
        check("t6_first_done", 32'(ok), 1);
        check("t6_busy_on_done", 32'(busy), 0);
        check("t6_first_beats", 32'(beat_q.size()), 2);
        clear_logs();
        kick(5'd5, 6'd2);
        check("t6_busy_again", 32'(busy), 1);
        wait_done(20, 1'b0, ok);
        check("t6_second_done", 32'(ok), 1);
        check("t6_beats", 32'(beat_q.size()), 2);
        check("t6_data0", beat_q[0], 32'hA500_0005);
        check("t6_data1", beat_q[1], 32'hA500_0006);
        check("t6_last1", 32'(last_q[1]), 1);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
